xbar_l2_bank_responder: RTL and testbench



---
 rtl/xbar_l2_pkg.sv | 21 ++
 rtl/xbar_l2_resp_pipe.sv | 35 +++
 rtl/xbar_l2_bank_responder.sv | 96 +++++++++
 tb/tb_xbar_l2_bank_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_l2_pkg.sv
// Shared widths, load/store encoding and response type for the L2 bank responder.
package xbar_l2_pkg;

    localparam int XBAR_L2_ADDR_WIDTH = 12;
    localparam int XBAR_L2_DATA_WIDTH = 32;
    localparam int XBAR_L2_BE_WIDTH   = XBAR_L2_DATA_WIDTH / 8;

    localparam logic WEN_STORE = 1'b0;
    localparam logic WEN_LOAD  = 1'b1;

    typedef struct packed {
        logic                          valid;
        logic [XBAR_L2_DATA_WIDTH-1:0] rdata;
    } xbar_l2_resp_t;

    // Counter width for a 0..period-1 counter; never narrower than one bit.
    function automatic int stall_cnt_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/xbar_l2_resp_pipe.sv
// Fixed-latency response delay line; one entry enters every cycle, cleared on reset.
module xbar_l2_resp_pipe
    import xbar_l2_pkg::*;
#(
    parameter int RESP_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  xbar_l2_resp_t resp_i,
    output xbar_l2_resp_t resp_o
);

    xbar_l2_resp_t stage_q [RESP_LATENCY];
    xbar_l2_resp_t stage_d [RESP_LATENCY];

    always_comb begin
        stage_d[0] = resp_i;
        for (int i = 1; i < RESP_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RESP_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign resp_o = stage_q[RESP_LATENCY-1];

endmodule

// File: rtl/xbar_l2_bank_responder.sv
// L2 bank slave: byte-enabled SRAM, fixed-latency responses, optional periodic grant stalls.
module xbar_l2_bank_responder
    import xbar_l2_pkg::*;
#(
    parameter int ADDR_WIDTH   = XBAR_L2_ADDR_WIDTH,
    parameter int DATA_WIDTH   = XBAR_L2_DATA_WIDTH,
    parameter int BE_WIDTH     = XBAR_L2_BE_WIDTH,
    parameter int RESP_LATENCY = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_i,
    input  logic [ADDR_WIDTH-1:0] mem_add_i,
    input  logic                  mem_wen_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    input  logic [BE_WIDTH-1:0]   mem_be_i,
    output logic                  mem_gnt_o,
    output logic                  mem_r_valid_o,
    output logic [DATA_WIDTH-1:0] mem_r_rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SCW   = stall_cnt_width(STALL_PERIOD);
    localparam logic [SCW-1:0] STALL_LAST = (STALL_PERIOD > 0) ? SCW'(STALL_PERIOD - 1) : '0;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [SCW-1:0]        stall_cnt_q, stall_cnt_d;
    logic                  stall;
    logic                  accept, store_acc, load_acc;
    logic [DATA_WIDTH-1:0] rd_word, wr_word;
    xbar_l2_resp_t         resp_in, resp_out;

    // Stall phase runs freely from reset release, regardless of traffic.
    always_comb begin
        stall       = 1'b0;
        stall_cnt_d = '0;
        if (STALL_PERIOD != 0) begin
            stall       = (stall_cnt_q == STALL_LAST);
            stall_cnt_d = stall ? '0 : stall_cnt_q + SCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_gnt_o = mem_req_i & ~stall;
    assign accept    = mem_req_i & mem_gnt_o;
    assign store_acc = accept & (mem_wen_i == WEN_STORE);
    assign load_acc  = accept & (mem_wen_i == WEN_LOAD);

    assign rd_word = mem_q[mem_add_i];

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (mem_be_i[i]) begin
                wr_word[8*i +: 8] = mem_wdata_i[8*i +: 8];
            end
        end
    end

    // Array is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            mem_q[mem_add_i] <= wr_word;
        end
    end

    // Loads sample the array on the accept edge, so a store on an earlier edge is visible.
    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        if (load_acc) begin
            resp_in.rdata = XBAR_L2_DATA_WIDTH'(rd_word);
        end
    end

    xbar_l2_resp_pipe #(
        .RESP_LATENCY (RESP_LATENCY)
    ) u_resp_pipe (
        .clk    (clk),
        .rst    (rst),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    assign mem_r_valid_o = resp_out.valid;
    assign mem_r_rdata_o = DATA_WIDTH'(resp_out.rdata);

endmodule

// File: tb/tb_xbar_l2_bank_responder.sv
// Scoreboard bench: three responder instances (lat1, lat3, lat1+stall3) driven with directed vectors.
module tb_xbar_l2_bank_responder;
    import xbar_l2_pkg::*;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;

    logic [NI-1:0]        req, wen;
    logic [NI-1:0][11:0]  add;
    logic [NI-1:0][31:0]  wdata;
    logic [NI-1:0][3:0]   be;
    wire  [NI-1:0]        gnt, rvalid;
    wire  [NI-1:0][31:0]  rdata;

    typedef struct {
        int          k;
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t exp_q [$];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int rel_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) rel_cyc <= 0;
        else     rel_cyc <= rel_cyc + 1;
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 1) ? 3 : 1;
        localparam int S = (g == 2) ? 3 : 0;
        xbar_l2_bank_responder #(
            .ADDR_WIDTH   (12),
            .DATA_WIDTH   (32),
            .BE_WIDTH     (4),
            .RESP_LATENCY (L),
            .STALL_PERIOD (S)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .mem_req_i     (req[g]),
            .mem_add_i     (add[g]),
            .mem_wen_i     (wen[g]),
            .mem_wdata_i   (wdata[g]),
            .mem_be_i      (be[g]),
            .mem_gnt_o     (gnt[g]),
            .mem_r_valid_o (rvalid[g]),
            .mem_r_rdata_o (rdata[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int stp_of(input int k);
        return (k == 2) ? 3 : 0;
    endfunction

    // Monitor: pop the oldest expectation for the responding instance.
    always @(negedge clk) begin
        int idx;
        for (int k = 0; k < NI; k++) begin
            if (rvalid[k] === 1'b1) begin
                idx = -1;
                foreach (exp_q[i]) begin
                    if (idx < 0 && exp_q[i].k == k) idx = i;
                end
                n_cmp++;
                if (idx < 0) begin
                    n_mis++;
                    $display("FAIL unexpected_rvalid inst%0d cyc%0d: got r_valid=1 rdata=%h, required no response", k, cyc, rdata[k]);
                end else begin
                    if (rdata[k] !== exp_q[idx].d || cyc != exp_q[idx].due) begin
                        n_mis++;
                        $display("FAIL resp inst%0d: got rdata=%h at cyc %0d, required rdata=%h at cyc %0d",
                                 k, rdata[k], cyc, exp_q[idx].d, exp_q[idx].due);
                    end
                    exp_q.delete(idx);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic xfer(input int k, input logic w, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input logic [31:0] exp_d, input bit push);
        bit   done;
        bit   eg;
        exp_t e;
        done = 1'b0;
        for (int t = 0; t < 8 && !done; t++) begin
            req[k] = 1'b1; wen[k] = w; add[k] = a; wdata[k] = wd; be[k] = b;
            #1;
            eg = (stp_of(k) == 0) || ((rel_cyc % stp_of(k)) != stp_of(k) - 1);
            n_cmp++;
            if (gnt[k] !== eg) begin
                n_mis++;
                $display("FAIL gnt inst%0d add=%h cyc%0d: got %b, required %b", k, a, cyc, gnt[k], eg);
            end
            if (gnt[k] === 1'b1) begin
                if (push) begin
                    e.k = k; e.d = exp_d; e.due = cyc + lat_of(k);
                    exp_q.push_back(e);
                end
                done = 1'b1;
            end
            @(negedge clk);
        end
        req[k] = 1'b0;
        if (!done) begin
            n_cmp++; n_mis++;
            $display("FAIL accept_timeout inst%0d add=%h: got no grant, required a grant", k, a);
        end
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [8:0] stall_pat;
        int         nxt;
        exp_t       e;

        rst = 1'b1; req = '0; wen = '0; add = '0; wdata = '0; be = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                n_mis++;
                $display("FAIL reset_outputs inst%0d: got valid=%b rdata=%h, required 0/0", k, rvalid[k], rdata[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;

        // Full store then load; store response carries zero data.
        xfer(0, WEN_STORE, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1);
        xfer(0, WEN_LOAD,  12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1);
        // Partial byte-enable merges and a be=0 no-op.
        xfer(0, WEN_STORE, 12'h020, 32'h11223344, 4'hF, 32'h0,        1);
        xfer(0, WEN_STORE, 12'h020, 32'hAABBCCDD, 4'h5, 32'h0,        1);
        xfer(0, WEN_LOAD,  12'h020, 32'h0,        4'h0, 32'h11BB33DD, 1);
        xfer(0, WEN_STORE, 12'h020, 32'hFFFFFFFF, 4'h0, 32'h0,        1);
        xfer(0, WEN_LOAD,  12'h020, 32'h0,        4'h0, 32'h11BB33DD, 1);
        xfer(0, WEN_STORE, 12'h020, 32'h55667788, 4'hA, 32'h0,        1);
        xfer(0, WEN_LOAD,  12'h020, 32'h0,        4'h0, 32'h55BB77DD, 1);
        // Same-address store/load/load/store/load, back to back.
        xfer(0, WEN_STORE, 12'h030, 32'h5A5A5A5A, 4'hF, 32'h0,        1);
        xfer(0, WEN_LOAD,  12'h030, 32'h0,        4'h0, 32'h5A5A5A5A, 1);
        xfer(0, WEN_LOAD,  12'h030, 32'h0,        4'h0, 32'h5A5A5A5A, 1);
        xfer(0, WEN_STORE, 12'h030, 32'h00000000, 4'hF, 32'h0,        1);
        xfer(0, WEN_LOAD,  12'h030, 32'h0,        4'h0, 32'h00000000, 1);
        idle(3);

        // Latency 3: consecutive loads give consecutive responses in address order.
        for (int i = 1; i <= 4; i++) xfer(1, WEN_STORE, 12'(i), 32'h1000_0000 + 32'(i), 4'hF, 32'h0, 1);
        for (int i = 1; i <= 4; i++) xfer(1, WEN_LOAD,  12'(i), 32'h0, 4'h0, 32'h1000_0000 + 32'(i), 1);
        idle(5);

        // Preload the stalling instance; grants follow the free-running stall phase.
        for (int i = 0; i < 6; i++) xfer(2, WEN_STORE, 12'(32'h100 + i), 32'hA000_0000 + 32'(i), 4'hF, 32'h0, 1);
        idle(4);

        // Two loads in flight on the latency-3 instance, then reset flushes them.
        xfer(1, WEN_LOAD, 12'h001, 32'h0, 4'h0, 32'h0, 0);
        xfer(1, WEN_LOAD, 12'h002, 32'h0, 4'h0, 32'h0, 0);
        rst = 1'b1;
        exp_q.delete();
        repeat (3) begin
            #1;
            n_cmp++;
            if (rvalid[1] !== 1'b0) begin
                n_mis++;
                $display("FAIL flush_in_reset cyc%0d: got r_valid=%b, required 0", cyc, rvalid[1]);
            end
            @(negedge clk);
        end
        rst = 1'b0;

        // Held request right after release: gnt low on cycles 2, 5, 8.
        stall_pat = 9'b011011011;
        nxt = 0;
        for (int i = 0; i < 9; i++) begin
            req[2] = 1'b1; wen[2] = WEN_LOAD; add[2] = 12'(32'h100 + nxt); be[2] = 4'h0;
            #1;
            n_cmp++;
            if (gnt[2] !== stall_pat[i]) begin
                n_mis++;
                $display("FAIL stall_gnt cycle%0d: got %b, required %b", i, gnt[2], stall_pat[i]);
            end
            n_cmp++;
            if (rvalid[1] !== 1'b0) begin
                n_mis++;
                $display("FAIL flush_after_reset cycle%0d: got r_valid=%b, required 0", i, rvalid[1]);
            end
            if (gnt[2] === 1'b1) begin
                e.k = 2; e.d = 32'hA000_0000 + 32'(nxt); e.due = cyc + 1;
                exp_q.push_back(e);
                nxt++;
            end
            @(negedge clk);
        end
        req[2] = 1'b0;
        n_cmp++;
        if (nxt != 6) begin
            n_mis++;
            $display("FAIL stall_accept_count: got %0d, required 6", nxt);
        end

        // Memory survives reset.
        xfer(1, WEN_LOAD, 12'h003, 32'h0, 4'h0, 32'h1000_0003, 1);
        xfer(0, WEN_LOAD, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1);
        xfer(2, WEN_LOAD, 12'h105, 32'h0, 4'h0, 32'hA000_0005, 1);
        idle(2);

        for (int t = 0; t < 30 && exp_q.size() != 0; t++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
